fetch_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 19 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: machine widths, FSM states and the decode-side entry payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RESET,
    RUN,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; flush overrides push and pop in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = wdata;
        wptr_d        = wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory request issue, response tagging and decode buffer.
// Optional misaligned-redirect fault enabled by `define FETCH_MISALIGN_CHECK_EN.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH      = 2,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_fault
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = ((OW > FW) ? OW : FW) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            fault_q, fault_d;

  logic [OW-1:0]   outstanding;
  logic [FW-1:0]   fifo_count;
  logic [XLEN-1:0] resp_pc;
  logic            req_fire, resp_keep, fifo_pop;
  logic            redir_misaligned;
  logic [XLEN-1:0] redir_target;
  fetch_entry_t    push_entry, head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  assign redir_misaligned = 1'b0;
`endif
  assign redir_target = {redirect_pc[XLEN-1:2], 2'b00};

  // Credit check keeps every in-flight response guaranteed a buffer slot.
  assign imem_req_valid = (state_q == RUN) && fetch_en && !redirect_valid
                          && (outstanding < OW'(MAX_OUTSTANDING))
                          && ((SW'(outstanding) + SW'(fifo_count)) < SW'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_keep      = imem_resp_valid && (drop_cnt_q == '0);
  assign fifo_pop       = instr_valid && instr_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    fault_d    = fault_q;
    case (state_q)
      RESET:   state_d = RUN;
      RUN:     if (!fetch_en) state_d = HALT;
      HALT:    if (fetch_en && !fault_q) state_d = RUN;
      default: state_d = RESET;
    endcase
    if (req_fire) begin
      pc_d = pc_q + XLEN'(4);
    end
    if (imem_resp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - OW'(1);
    end
    // Every response still in flight belongs to the old path and must be dropped.
    if (redirect_valid) begin
      pc_d       = redir_target;
      drop_cnt_d = outstanding - OW'(imem_resp_valid);
      fault_d    = redir_misaligned;
      if (redir_misaligned) state_d = HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET;
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
      fault_q    <= fault_d;
    end
  end

  // PC tags stay in step with memory order, so they are never flushed.
  sync_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (XLEN)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (1'b0),
    .push  (req_fire),
    .wdata (pc_q),
    .pop   (imem_resp_valid),
    .rdata (resp_pc),
    .count (outstanding)
  );

  assign push_entry = '{instr: imem_resp_data, pc: resp_pc};

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_instr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (resp_keep),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (head_entry),
    .count (fifo_count)
  );

  assign instr_valid = (fifo_count != '0);
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: program-order PC model, in-order memory model, random traffic.
module tb_fetch_unit;

  localparam int unsigned MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  fetch_unit #(
    .RESET_PC        (32'h0000_0000),
    .FIFO_DEPTH      (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_req[$];
  logic [31:0] exp_dec[$];
  logic [31:0] pend[$];
  bit          hold = 1'b0;
  bit          det = 1'b1;
  bit          post_redirect = 1'b0;
  bit          want_hit = 1'b0;
  logic [31:0] want_pc = '0;
  int          req_seen = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Program order after a (re)start: target, target+4, ... wrapping at 32 bits.
  task automatic restart(input logic [31:0] t);
    exp_req.delete();
    exp_dec.delete();
    for (int i = 0; i < 8; i++) begin
      exp_req.push_back(t + 32'(4 * i));
      exp_dec.push_back(t + 32'(4 * i));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    restart({t[31:2], 2'b00});
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_dec(input logic [31:0] pc, input int budget);
    int n = 0;
    want_pc  = pc;
    want_hit = 1'b0;
    while (!want_hit && n < budget) begin
      tick();
      n++;
    end
    chk("reach_pc", 32'(want_hit), 32'd1);
  endtask

  // In-order memory: answers the oldest accepted request, never earlier than the next cycle.
  always begin : mem_model
    bit          rq, rs;
    logic [31:0] a;
    @(negedge clk);
    rq = rst_n && imem_req_valid && imem_req_ready;
    rs = rst_n && imem_resp_valid;
    a  = imem_req_addr;
    @(posedge clk);
    #1;
    if (rq) pend.push_back(a);
    if (rs && pend.size() > 0) void'(pend.pop_front());
    imem_req_ready = det ? 1'b1 : ($urandom_range(99) < 75);
    if (pend.size() > 0 && !hold && (det || $urandom_range(99) < 60)) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  end

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (rst_n) begin
      if (redirect_valid) chk("req_during_redirect", 32'(imem_req_valid), 32'd0);
      if (post_redirect) chk("flushed_after_redirect", 32'(instr_valid), 32'd0);
      if (imem_req_valid && imem_req_ready) begin
        req_seen++;
        chk("req_credit", 32'(pend.size() < MAXO), 32'd1);
        if (exp_req.size() < 4) exp_req.push_back(exp_req[$] + 32'd4);
        e = exp_req.pop_front();
        chk("req_addr", imem_req_addr, e);
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        if (exp_dec.size() < 4) exp_dec.push_back(exp_dec[$] + 32'd4);
        e = exp_dec.pop_front();
        chk("instr_pc", instr_pc, e);
        chk("instr_data", instr, mem_word(e));
        if (instr_pc == want_pc) want_hit = 1'b1;
      end
    end
    post_redirect = rst_n && redirect_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] last_buf;
    bit          found;
    int          rs0;
    restart(32'h0);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'd0);

    rst_n = 1'b1;
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    #3;
    chk("reset_state_no_req", 32'(imem_req_valid), 32'd0);
    tick();

    // Straight-line fetch 0x0, 0x4, 0x8.
    wait_dec(32'h8, 40);

    // Decode stall: buffer fills, requests stop, nothing lost on release.
    instr_ready = 1'b0;
    repeat (10) tick();
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_outstanding", 32'(pend.size()), 32'd0);
    chk("stall_instr_valid", 32'(instr_valid), 32'd1);
    last_buf = exp_dec[1];
    instr_ready = 1'b1;
    wait_dec(last_buf, 20);

    // Redirect with two requests in flight.
    hold = 1'b1;
    repeat (8) tick();
    chk("two_outstanding", 32'(pend.size()), 32'd2);
    redirect(32'h100);
    hold = 1'b0;
    wait_dec(32'h100, 40);

    // Redirect in the same cycle as a response.
    hold = 1'b1;
    repeat (8) tick();
    hold = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (imem_resp_valid) begin
        found = 1'b1;
        rs0 = pend.size();
        redirect(32'h300);
      end
    end
    chk("resp_redirect_same_cycle", 32'(found), 32'd1);
    wait_dec(32'h300, 40);

    // PC wrap.
    redirect(32'hFFFF_FFFC);
    wait_dec(32'h4, 40);

`ifdef FETCH_MISALIGN_CHECK_EN
    redirect(32'h102);
    chk("fault_set", 32'(fetch_fault), 32'd1);
    rs0 = req_seen;
    repeat (10) tick();
    chk("fault_no_req", 32'(req_seen - rs0), 32'd0);
    chk("fault_sticky", 32'(fetch_fault), 32'd1);
    redirect(32'h200);
    chk("fault_clear", 32'(fetch_fault), 32'd0);
    wait_dec(32'h200, 40);
`else
    redirect(32'h102);
    chk("no_fault_feature", 32'(fetch_fault), 32'd0);
    wait_dec(32'h104, 40);
`endif

    // Randomised traffic.
    det = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      fetch_en    = ($urandom_range(9) != 0);
      instr_ready = ($urandom_range(9) < 7);
      if ($urandom_range(99) < 3) begin
        if ($urandom_range(3) == 0) redirect(32'hFFFF_FFF0 + 32'(4 * $urandom_range(3)));
        else redirect($urandom & 32'hFFFF_FFFC);
      end else begin
        tick();
      end
    end

    // Drain on a known path.
    det = 1'b1;
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    redirect(32'h400);
    wait_dec(32'h40C, 60);
    chk("final_fault", 32'(fetch_fault), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
